// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: initiator FSM state encoding and response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } axi_master_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Any code other than OKAY is reported to the client as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle (32-bit address/data, byte strobes) with initiator and target views.
interface axi_lite_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4-Lite initiator for the load/store unit.
// Define AXI_MASTER_TIMEOUT_EN to add the per-transaction watchdog (sticky timeout flag).
module lsu_axi_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              timeout,
    output axi_master_state_e dbg_state,
    axi_lite_if.master        m
);

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both high; once raised, valid and its payload stay fixed until then.

    axi_master_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        rready_q, rready_d;
    logic        bready_q, bready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("lsu_axi_master: TIMEOUT_CYCLES must be at least 1");
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        rready_d    = rready_q;
        bready_d    = bready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (m.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m.rdata;
                    rsp_err_d   = resp_is_err(m.rresp);
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; B is awaited only after both are gone.
                if (awvalid_q && m.awready) awvalid_d = 1'b0;
                if (wvalid_q && m.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = resp_is_err(m.bresp);
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            rready_q    <= rready_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    logic             tmo_busy;
    logic             tmo_hit;

    // The count restarts at acceptance and saturates at the limit, so each
    // transaction can trip the watchdog at most once.
    always_comb begin
        tmo_busy  = (state_q != IDLE) && (state_q != RSP);
        tmo_hit   = tmo_busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q | tmo_hit;
        if (req_valid && req_ready) begin
            tmo_cnt_d = '0;
        end else if (tmo_busy && (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES))) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            if (tmo_hit) begin
                $error("lsu_axi_master: transaction to address 0x%08h exceeded %0d cycles",
                       addr_q, TIMEOUT_CYCLES);
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

    assign m.arvalid = arvalid_q;
    assign m.araddr  = addr_q;
    assign m.rready  = rready_q;
    assign m.awvalid = awvalid_q;
    assign m.awaddr  = addr_q;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: scripted AXI4-Lite target, response scoreboard, handshake counters.
module tb_lsu_axi_master;
    import axi_lite_pkg::*;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif
    localparam int BUDGET = 200;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              timeout;
    axi_master_state_e dbg_state;

    axi_lite_if axi ();

    lsu_axi_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .timeout   (timeout),
        .dbg_state (dbg_state),
        .m         (axi)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          chk_count = 0;
    int          err_count = 0;
    logic [32:0] exp_q[$];
    logic        rsp_rand_en = 1'b0;
    int          aw_hs = 0;
    int          w_hs  = 0;
    int          b_hs  = 0;
    int          ar_hs = 0;
    int          r_hs  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (axi.awvalid && axi.awready) aw_hs <= aw_hs + 1;
        if (axi.wvalid && axi.wready)   w_hs  <= w_hs + 1;
        if (axi.bvalid && axi.bready)   b_hs  <= b_hs + 1;
        if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
        if (axi.rvalid && axi.rready)   r_hs  <= r_hs + 1;
    end

    // Client response side: picks rsp_ready, checks stability and pops the expected queue.
    initial begin
        logic [32:0] prev;
        logic [32:0] exp;
        logic        hold;
        hold      = 1'b0;
        prev      = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = rsp_rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rsp_valid) begin
                chk("req_ready_in_rsp", req_ready, 0);
                if (hold) chk("rsp_stable", {rsp_err, rsp_rdata}, prev);
                if (rsp_ready) begin
                    chk("rsp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, exp[31:0]);
                        chk("rsp_err", rsp_err, exp[32]);
                    end
                end
            end
            hold = rsp_valid && !rsp_ready;
            prev = {rsp_err, rsp_rdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        n = 0;
        while (!req_ready && n < BUDGET) begin @(negedge clk); n++; end
        chk("req_accept_wait", n < BUDGET, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        chk("req_ready_busy", req_ready, 0);
        if (we) begin
            chk("awvalid_lat1", axi.awvalid, 1);
            chk("wvalid_lat1", axi.wvalid, 1);
        end else begin
            chk("arvalid_lat1", axi.arvalid, 1);
        end
    endtask

    task automatic slave_ar(input logic [31:0] addr, input int dly);
        int n;
        n = 0;
        while (!axi.arvalid && n < BUDGET) begin @(negedge clk); n++; end
        chk("ar_wait", n < BUDGET, 1);
        for (int i = 0; i < dly; i++) begin
            chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, addr});
            @(negedge clk);
        end
        chk("araddr", axi.araddr, addr);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        chk("arvalid_drop", axi.arvalid, 0);
        chk("rready_up", axi.rready, 1);
    endtask

    task automatic slave_r(input logic [31:0] rdata, input logic [1:0] rresp);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        axi.rvalid = 1'b1;
        axi.rdata  = rdata;
        axi.rresp  = rresp;
        n = 0;
        while (!axi.rready && n < BUDGET) begin @(negedge clk); n++; end
        chk("r_wait", n < BUDGET, 1);
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = $urandom;
        axi.rresp  = AXI_RESP_OKAY;
        chk("rready_drop", axi.rready, 0);
    endtask

    task automatic slave_aw(input logic [31:0] addr, input int dly);
        int n;
        n = 0;
        while (!axi.awvalid && n < BUDGET) begin @(negedge clk); n++; end
        chk("aw_wait", n < BUDGET, 1);
        for (int i = 0; i < dly; i++) begin
            chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, addr});
            @(negedge clk);
        end
        chk("awaddr", axi.awaddr, addr);
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        chk("awvalid_drop", axi.awvalid, 0);
    endtask

    task automatic slave_w(input logic [31:0] wdata, input logic [3:0] wstrb, input int dly);
        int n;
        n = 0;
        while (!axi.wvalid && n < BUDGET) begin @(negedge clk); n++; end
        chk("w_wait", n < BUDGET, 1);
        for (int i = 0; i < dly; i++) begin
            chk("w_hold", {axi.wvalid, axi.wstrb, axi.wdata}, {1'b1, wstrb, wdata});
            @(negedge clk);
        end
        chk("wdata", {axi.wstrb, axi.wdata}, {wstrb, wdata});
        axi.wready = 1'b1;
        @(negedge clk);
        axi.wready = 1'b0;
        chk("wvalid_drop", axi.wvalid, 0);
    endtask

    task automatic slave_b(input logic [1:0] bresp);
        int n;
        chk("bready_up", axi.bready, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        axi.bvalid = 1'b1;
        axi.bresp  = bresp;
        n = 0;
        while (!axi.bready && n < BUDGET) begin @(negedge clk); n++; end
        chk("b_wait", n < BUDGET, 1);
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = AXI_RESP_OKAY;
        chk("bready_drop", axi.bready, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin @(negedge clk); n++; end
        chk("rsp_wait", n < BUDGET, 1);
        @(negedge clk);
        chk("back_to_idle", req_ready, 1);
        chk("rsp_valid_low", rsp_valid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly,
                           input logic [31:0] rdata, input logic [1:0] rresp);
        int ar0, r0;
        ar0 = ar_hs;
        r0  = r_hs;
        exp_q.push_back({rresp != AXI_RESP_OKAY, rdata});
        send_req(1'b0, addr, 32'h0, 4'h0);
        slave_ar(addr, ar_dly);
        slave_r(rdata, rresp);
        wait_idle();
        chk("ar_count", ar_hs - ar0, 1);
        chk("r_count", r_hs - r0, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int aw_dly, input int w_dly,
                            input logic [1:0] bresp);
        int aw0, w0, b0;
        aw0 = aw_hs;
        w0  = w_hs;
        b0  = b_hs;
        exp_q.push_back({bresp != AXI_RESP_OKAY, 32'h0});
        send_req(1'b1, addr, wdata, wstrb);
        fork
            slave_aw(addr, aw_dly);
            slave_w(wdata, wstrb, w_dly);
        join
        slave_b(bresp);
        wait_idle();
        chk("aw_count", aw_hs - aw0, 1);
        chk("w_count", w_hs - w0, 1);
        chk("b_count", b_hs - b0, 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_arvalid"}, axi.arvalid, 0);
        chk({tag, "_awvalid"}, axi.awvalid, 0);
        chk({tag, "_wvalid"}, axi.wvalid, 0);
        chk({tag, "_rready"}, axi.rready, 0);
        chk({tag, "_bready"}, axi.bready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = AXI_RESP_OKAY;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = AXI_RESP_OKAY;

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready_after_por", req_ready, 1);

        // Directed cases
        do_read(32'hA000_03F8, 2, 32'h0000_0000, AXI_RESP_OKAY);
        do_write(32'hA000_03F8, 32'h0000_0041, 4'b0001, 0, 0, AXI_RESP_OKAY);
        do_write(32'hA000_03FC, 32'h1234_5678, 4'b1111, 3, 0, AXI_RESP_OKAY);
        do_write(32'h8000_0000, 32'h5A5A_A5A5, 4'b1111, 0, 0, AXI_RESP_EXOKAY);
        do_write(32'h8000_0010, 32'h0BAD_F00D, 4'b0110, 0, 2, AXI_RESP_SLVERR);
        do_read(32'h0000_1000, 0, 32'hDEAD_BEEF, AXI_RESP_SLVERR);
        do_read(32'h0000_1004, 1, 32'h8765_4321, AXI_RESP_DECERR);

        // Randomised traffic with a hesitant client
        rsp_rand_en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            logic [31:0] a;
            a = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), 2'($urandom_range(0, 3)));
            end else begin
                do_read(a, $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)));
            end
        end
        rsp_rand_en = 1'b0;

        // Reset while waiting for read data
        do_read(32'h2000_0000, 1, 32'hCAFE_F00D, AXI_RESP_OKAY);
        chk("rdata_before_reset", rsp_rdata, 32'hCAFE_F00D);
        send_req(1'b0, 32'h2000_0004, 32'h0, 4'h0);
        slave_ar(32'h2000_0004, 1);
        chk("in_rd_data", dbg_state, RD_DATA);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", req_ready, 1);
        do_read(32'h2000_0008, 0, 32'h0000_00FF, AXI_RESP_OKAY);

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog with a target that never raises arready
        exp_q.push_back({1'b0, 32'h0000_1234});
        send_req(1'b0, 32'hA000_0010, 32'h0, 4'h0);
        for (int k = 1; k <= int'(TMO); k++) begin
            @(negedge clk);
            chk("timeout_cycle", timeout, k >= int'(TMO));
            chk("arvalid_held", axi.arvalid, 1);
        end
        slave_ar(32'hA000_0010, 0);
        slave_r(32'h0000_1234, AXI_RESP_OKAY);
        wait_idle();
        chk("timeout_sticky", timeout, 1);
`else
        chk("timeout_tied", timeout, 0);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_time_limit got=expired exp=done");
        $fatal(1, "simulation time limit reached");
    end

endmodule
